stream_arb_mux: RTL and testbench

Parametrised N-channel, valid/ready, registered multiplexer with selectable round-robin or fixed-priority arbitration and packet locking. It is the sequential successor of the plain select-driven muxes in the datapath. It merges request streams from several producers, such as instruction fetch, data load/store and a debug port, onto one memory/bus request channel. A single output register isolates timing on the merged side.

---
 rtl/stream_arb_mux_pkg.sv | 15 +
 rtl/stream_arb_mux_rr_pick.sv | 35 +++
 rtl/stream_arb_mux.sv | 89 ++++++++
 tb/tb_stream_arb_mux.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_mux_pkg.sv
// Shared helpers for the stream arbiter/mux: index-width derivation.
package stream_arb_mux_pkg;

    localparam int MIN_IDXW = 1;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < MIN_IDXW) ? MIN_IDXW : w;
    endfunction

endpackage

// File: rtl/stream_arb_mux_rr_pick.sv
// Combinational picker: first requesting channel, searched from ptr (round-robin) or from 0.
module stream_arb_mux_rr_pick
    import stream_arb_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    input  logic            rr_en,
    output logic [IDXW-1:0] grant,
    output logic            any
);

    always_comb begin
        int s;
        logic [IDXW-1:0] idx;
        s     = 0;
        idx   = '0;
        grant = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            s = rr_en ? (int'(ptr) + k) : k;
            if (s >= N) begin
                s = s - N;
            end
            idx = IDXW'(s);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel valid/ready mux with packet locking and a single registered output stage.
module stream_arb_mux
    import stream_arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int IDXW  = clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rr_en,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [IDXW-1:0]    out_sel,
    input  logic               out_ready,
    output logic               locked
);

    localparam logic [N-1:0]    ONE_HOT0 = N'(1);
    localparam logic [IDXW-1:0] LAST_CH  = IDXW'(N - 1);

    logic [IDXW-1:0]  lock_ch;
    logic [IDXW-1:0]  ptr;
    logic [N-1:0]     req;
    logic [IDXW-1:0]  grant;
    logic             any;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] chan_data [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            chan_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // While a packet is open only its owner may compete.
    assign req    = locked ? (in_valid & (ONE_HOT0 << lock_ch)) : in_valid;
    assign load   = !out_valid || out_ready;
    assign accept = load && any;

    stream_arb_mux_rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .rr_en (rr_en),
        .grant (grant),
        .any   (any)
    );

    assign in_ready = accept ? (ONE_HOT0 << grant) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            locked    <= 1'b0;
            lock_ch   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= chan_data[grant];
            out_last  <= in_last[grant];
            out_sel   <= grant;
            if (!in_last[grant]) begin
                locked  <= 1'b1;
                lock_ch <= grant;
            end else begin
                locked <= 1'b0;
                // Pointer moves per packet, so fairness is counted in packets.
                if (rr_en) begin
                    ptr <= (grant == LAST_CH) ? '0 : grant + IDXW'(1);
                end
            end
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: a 4-channel instance and a 3-channel instance.
module tb_stream_arb_mux;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'h3333_0002;
    localparam logic [31:0] D3 = 32'h4444_0003;

    logic        clk;
    logic        reset_n;

    logic        a_rr_en;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_last;
    logic [127:0] a_in_data;
    logic [3:0]  a_in_ready;
    logic        a_out_valid;
    logic [31:0] a_out_data;
    logic        a_out_last;
    logic [1:0]  a_out_sel;
    logic        a_out_ready;
    logic        a_locked;

    logic        b_rr_en;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_last;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_ready;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic        b_out_last;
    logic [1:0]  b_out_sel;
    logic        b_out_ready;
    logic        b_locked;

    int vectors = 0;
    int fails   = 0;

    stream_arb_mux #(.WIDTH(32), .N(4)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .rr_en     (a_rr_en),
        .in_valid  (a_in_valid),
        .in_last   (a_in_last),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .out_sel   (a_out_sel),
        .out_ready (a_out_ready),
        .locked    (a_locked)
    );

    stream_arb_mux #(.WIDTH(8), .N(3)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .rr_en     (b_rr_en),
        .in_valid  (b_in_valid),
        .in_last   (b_in_last),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .out_sel   (b_out_sel),
        .out_ready (b_out_ready),
        .locked    (b_locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_out(input string tag, input logic v, input logic [1:0] sel,
                               input logic [31:0] data, input logic lst, input logic lk);
        check({tag, ".out_valid"}, 64'(a_out_valid), 64'(v));
        check({tag, ".out_sel"},   64'(a_out_sel),   64'(sel));
        check({tag, ".out_data"},  64'(a_out_data),  64'(data));
        check({tag, ".out_last"},  64'(a_out_last),  64'(lst));
        check({tag, ".locked"},    64'(a_locked),    64'(lk));
    endtask

    initial begin
        logic [1:0]  rr_seq [5];
        logic [31:0] rr_dat [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_dat = '{D0, D1, D2, D3, D0};

        reset_n     = 1'b0;
        a_rr_en     = 1'b1;
        a_in_valid  = 4'b0000;
        a_in_last   = 4'b0000;
        a_in_data   = {D3, D2, D1, D0};
        a_out_ready = 1'b1;
        b_rr_en     = 1'b1;
        b_in_valid  = 3'b000;
        b_in_last   = 3'b000;
        b_in_data   = {8'h33, 8'h22, 8'h11};
        b_out_ready = 1'b1;

        #3;
        check_a_out("reset", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        check("reset.in_ready", 64'(a_in_ready), 64'h0);
        check("reset.b_out_valid", 64'(b_out_valid), 64'h0);
        tick();
        tick();
        reset_n = 1'b1;

        // Round robin, all channels valid, single-beat packets.
        a_in_valid = 4'b1111;
        a_in_last  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rr%0d.in_ready", i), 64'(a_in_ready), 64'(4'b0001 << rr_seq[i]));
            tick();
            check_a_out($sformatf("rr%0d", i), 1'b1, rr_seq[i], rr_dat[i], 1'b1, 1'b0);
        end
        a_in_valid = 4'b0000;
        #1;
        check("idle.in_ready", 64'(a_in_ready), 64'h0);
        tick();
        check_a_out("idle", 1'b0, 2'd0, D0, 1'b1, 1'b0);

        // Fixed priority: ch1 and ch3 valid, ch1 always wins.
        a_rr_en    = 1'b0;
        a_in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("fp%0d.in_ready", i), 64'(a_in_ready), 64'(4'b0010));
            tick();
            check_a_out($sformatf("fp%0d", i), 1'b1, 2'd1, D1, 1'b1, 1'b0);
        end
        a_in_valid = 4'b0000;
        tick();
        check("fp_idle.out_valid", 64'(a_out_valid), 64'h0);

        // Packet lock: ch2 sends 3 beats while ch0 waits (ptr is 1).
        a_rr_en    = 1'b1;
        a_in_valid = 4'b0101;
        a_in_last  = 4'b0001;
        #1;
        check("lk1.in_ready", 64'(a_in_ready), 64'(4'b0100));
        tick();
        check_a_out("lk1", 1'b1, 2'd2, D2, 1'b0, 1'b1);
        check("lk2.in_ready", 64'(a_in_ready), 64'(4'b0100));
        tick();
        check_a_out("lk2", 1'b1, 2'd2, D2, 1'b0, 1'b1);
        a_in_last = 4'b0101;
        #1;
        check("lk3.in_ready", 64'(a_in_ready), 64'(4'b0100));
        tick();
        check_a_out("lk3", 1'b1, 2'd2, D2, 1'b1, 1'b0);
        check("lk4.in_ready", 64'(a_in_ready), 64'(4'b0001));
        tick();
        check_a_out("lk4", 1'b1, 2'd0, D0, 1'b1, 1'b0);

        // Lock owner drops valid mid-packet; mode toggled while locked.
        a_in_valid = 4'b0100;
        a_in_last  = 4'b0000;
        tick();
        check_a_out("drop1", 1'b1, 2'd2, D2, 1'b0, 1'b1);
        a_in_valid = 4'b0001;
        #1;
        check("drop2.in_ready", 64'(a_in_ready), 64'h0);
        tick();
        check("drop2.out_valid", 64'(a_out_valid), 64'h0);
        check("drop2.locked", 64'(a_locked), 64'h1);
        a_rr_en    = 1'b0;
        a_in_valid = 4'b0101;
        a_in_last  = 4'b0100;
        #1;
        check("drop3.in_ready", 64'(a_in_ready), 64'(4'b0100));
        tick();
        check_a_out("drop3", 1'b1, 2'd2, D2, 1'b1, 1'b0);
        a_in_last = 4'b0101;
        #1;
        check("drop4.in_ready", 64'(a_in_ready), 64'(4'b0001));
        tick();
        check_a_out("drop4", 1'b1, 2'd0, D0, 1'b1, 1'b0);

        // Back-pressure: ptr is 1, so ch1 then ch2.
        a_rr_en    = 1'b1;
        a_in_valid = 4'b1111;
        a_in_last  = 4'b1111;
        tick();
        check_a_out("bp0", 1'b1, 2'd1, D1, 1'b1, 1'b0);
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i + 1), 64'(a_in_ready), 64'h0);
            tick();
            check_a_out($sformatf("bp%0d", i + 1), 1'b1, 2'd1, D1, 1'b1, 1'b0);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_rel.in_ready", 64'(a_in_ready), 64'(4'b0100));
        tick();
        check_a_out("bp_rel", 1'b1, 2'd2, D2, 1'b1, 1'b0);
        a_in_valid = 4'b0000;
        tick();
        check("bp_idle.out_valid", 64'(a_out_valid), 64'h0);

        // Reset mid-packet (ptr is 3, so ch1 is found after wrapping).
        a_in_valid = 4'b0010;
        a_in_last  = 4'b0000;
        tick();
        check_a_out("rst_pre", 1'b1, 2'd1, D1, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_a_out("rst_mid", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        tick();
        reset_n    = 1'b1;
        a_in_valid = 4'b1111;
        a_in_last  = 4'b1111;
        #1;
        check("rst_post.in_ready", 64'(a_in_ready), 64'(4'b0001));
        tick();
        check_a_out("rst_post", 1'b1, 2'd0, D0, 1'b1, 1'b0);
        a_in_valid = 4'b0000;

        // N=3: ch2 packet wraps ptr to 0, so ch0 beats ch2 next.
        b_in_valid = 3'b100;
        b_in_last  = 3'b111;
        #1;
        check("n3a.in_ready", 64'(b_in_ready), 64'(3'b100));
        tick();
        check("n3a.out_sel", 64'(b_out_sel), 64'd2);
        check("n3a.out_data", 64'(b_out_data), 64'h33);
        b_in_valid = 3'b101;
        #1;
        check("n3b.in_ready", 64'(b_in_ready), 64'(3'b001));
        tick();
        check("n3b.out_sel", 64'(b_out_sel), 64'd0);
        check("n3b.out_data", 64'(b_out_data), 64'h11);
        check("n3b.out_valid", 64'(b_out_valid), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
